game_timer_ctrl: RTL

Game-phase sequencer for the stay-on-road timer path. It turns the start and pause buttons and the road collision signal into the run, clear and death controls consumed by the eight-digit timer/best-time display. It also drives a flash-blank signal for the death animation. The block sits between the button inputs and road logic on one side and the timer display on the other, all on the 100 MHz system clock.

---
 rtl/game_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 28 ++
 rtl/game_timer_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// game timer path (also used by timer_display).
package game_pkg;

  localparam int unsigned TICK_DIV_DEF = 1_000_000;
  localparam int unsigned GRACE_CS_DEF = 50;
  localparam int unsigned DYING_CS_DEF = 200;
  localparam int unsigned FLASH_CS_DEF = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DYING = 2'd3
  } game_state_e;

  // Counter width for a value range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus edge flop for a raw button; emits a one-cycle
// pulse on each rising edge, so a held button yields a single event.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign o_rise_c = r_sync2 & ~r_edge;

endmodule

// File: rtl/game_timer_ctrl.sv
// Game-phase sequencer: turns start/pause buttons and road collision into the
// run, clear, death and flash-blank controls for the timer display.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned GRACE_CS = GRACE_CS_DEF,
  parameter int unsigned DYING_CS = DYING_CS_DEF,
  parameter int unsigned FLASH_CS = FLASH_CS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_btn,
  input  logic       i_pause_btn,
  input  logic       i_collision,
  output logic       o_timer_run,
  output logic       o_timer_clr,
  output logic       o_dead,
  output logic       o_disp_blank,
  output logic [1:0] o_game_state
);

  localparam int unsigned DIV_W   = cnt_w(TICK_DIV);
  localparam int unsigned GRACE_W = cnt_w(GRACE_CS + 1);
  localparam int unsigned DYING_W = cnt_w(DYING_CS);
  localparam int unsigned FLASH_W = cnt_w(FLASH_CS);

  game_state_e        r_state;
  logic [DIV_W-1:0]   r_div;
  logic [GRACE_W-1:0] r_grace;
  logic [DYING_W-1:0] r_dying;
  logic [FLASH_W-1:0] r_flash;
  logic               r_timer_run;
  logic               r_timer_clr;
  logic               r_dead;
  logic               r_disp_blank;

  game_state_e        w_state_nxt;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [GRACE_W-1:0] w_grace_nxt;
  logic [DYING_W-1:0] w_dying_nxt;
  logic [FLASH_W-1:0] w_flash_nxt;
  logic               w_run_nxt;
  logic               w_clr_nxt;
  logic               w_dead_nxt;
  logic               w_blank_nxt;
  logic               w_tick;
  logic               w_start_rise;
  logic               w_pause_rise;

  btn_sync_edge u_start_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_start_btn),
    .o_rise_c (w_start_rise)
  );

  btn_sync_edge u_pause_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_pause_btn),
    .o_rise_c (w_pause_rise)
  );

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_grace      <= '0;
      r_dying      <= '0;
      r_flash      <= '0;
      r_timer_run  <= 1'b0;
      r_timer_clr  <= 1'b0;
      r_dead       <= 1'b0;
      r_disp_blank <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_grace      <= w_grace_nxt;
      r_dying      <= w_dying_nxt;
      r_flash      <= w_flash_nxt;
      r_timer_run  <= w_run_nxt;
      r_timer_clr  <= w_clr_nxt;
      r_dead       <= w_dead_nxt;
      r_disp_blank <= w_blank_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_tick ? '0 : r_div + DIV_W'(1);
    w_grace_nxt = r_grace;
    w_dying_nxt = r_dying;
    w_flash_nxt = r_flash;
    w_blank_nxt = r_disp_blank;
    w_clr_nxt   = 1'b0;
    w_dead_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_RUN;
          w_clr_nxt   = 1'b1;
          w_grace_nxt = GRACE_W'(GRACE_CS);
        end
      end
      ST_RUN: begin
        // Collision outranks a coincident pause edge, which is dropped.
        if (i_collision && (r_grace == '0)) begin
          w_state_nxt = ST_DYING;
          w_dead_nxt  = 1'b1;
          w_dying_nxt = '0;
          w_flash_nxt = '0;
          w_blank_nxt = 1'b1;
        end else if (w_pause_rise) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick && (r_grace != '0)) begin
          w_grace_nxt = r_grace - GRACE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (w_pause_rise) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DYING: begin
        if (w_tick) begin
          if (r_dying == DYING_W'(DYING_CS - 1)) begin
            w_state_nxt = ST_IDLE;
            w_dying_nxt = '0;
            w_flash_nxt = '0;
            w_blank_nxt = 1'b0;
          end else begin
            w_dying_nxt = r_dying + DYING_W'(1);
            if (r_flash == FLASH_W'(FLASH_CS - 1)) begin
              w_flash_nxt = '0;
              w_blank_nxt = ~r_disp_blank;
            end else begin
              w_flash_nxt = r_flash + FLASH_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Every phase change restarts the divider so durations are whole ticks.
    if (w_state_nxt != r_state) begin
      w_div_nxt = '0;
    end
    w_run_nxt = (w_state_nxt == ST_RUN);
  end

  assign o_timer_run  = r_timer_run;
  assign o_timer_clr  = r_timer_clr;
  assign o_dead       = r_dead;
  assign o_disp_blank = r_disp_blank;
  assign o_game_state = r_state;

endmodule
